// File: rtl/hack_video_pkg.sv
// Shared Hack video constants, the Screen address type and the row/word to address mapping.
package hack_video_pkg;

    localparam int SCREEN_WORDS  = 8192;
    localparam int WORDS_PER_ROW = 32;
    localparam int H_ACTIVE      = 512;
    localparam int SCREEN_ROWS   = 256;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    typedef logic [15:0] screen_addr_t;

    // Word address of (row, word-in-row): 32*row + word, always below SCREEN_WORDS.
    function automatic screen_addr_t row_col_to_addr(input logic [7:0] row, input logic [4:0] word);
        return {3'b000, row, word};
    endfunction

endpackage

// File: rtl/screen_scanner_video_timing.sv
// Raster timing: h/v counters, sync pulses, display enable and frame_start, all registered
// one clock behind the counters.
module video_timing
    import hack_video_pkg::*;
#(
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 256,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_END      = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] HS_START   = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W-1:0] HS_STOP    = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_END      = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] VS_START   = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] VS_STOP    = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_CNT_W-1:0] h_cnt_d, h_cnt_q;
    logic [V_CNT_W-1:0] v_cnt_d, v_cnt_q;
    logic de_d, de_q, hsync_d, hsync_q, vsync_d, vsync_q, frame_start_d, frame_start_q;

    // Counter advance and output decode of the current counter state.
    always_comb begin
        h_cnt_d = h_cnt_q + H_CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + V_CNT_W'(1);
            end
        end else begin
            v_cnt_d = v_cnt_q;
        end
        de_d          = (h_cnt_q < H_END) && (v_cnt_q < V_END);
        hsync_d       = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_STOP)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_STOP)) ? SYNC_POL : ~SYNC_POL;
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Counter and timing output registers; reset parks on the last blanking line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= V_LAST;
            de_q          <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: rtl/screen_scanner.sv
// Hack screen raster scanner: fetches Screen words and shifts them out LSB-first as pixels.
// Defining SCREEN_SCANNER_LINE_DOUBLE_EN shows every Hack row on two lines (512 active lines).
module screen_scanner
    import hack_video_pkg::*;
#(
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] scr_address,
    input  logic [15:0] scr_data,
    output logic        pixel,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
`ifdef SCREEN_SCANNER_LINE_DOUBLE_EN
    localparam int V_ACTIVE = 2 * SCREEN_ROWS;
`else
    localparam int V_ACTIVE = SCREEN_ROWS;
`endif
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_END  = H_CNT_W'(H_ACTIVE);
    localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_END  = V_CNT_W'(V_ACTIVE);

    logic [H_CNT_W-1:0] h_cnt_s;
    logic [V_CNT_W-1:0] v_cnt_s;
    logic [V_CNT_W-1:0] v_next_s;
    logic [7:0]         row_s, row_next_s;
    logic [4:0]         word_s;
    logic               active_s, last_word_s;
    screen_addr_t       addr_d, addr_q;
    logic [15:0]        pf_d, pf_q, sr_d, sr_q;
    logic               issue_d, issue_q, capture_d, capture_q;
    logic               pixel_d, pixel_q;

    video_timing #(
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_video_timing (
        .clk         (clk),
        .reset       (reset),
        .h_cnt       (h_cnt_s),
        .v_cnt       (v_cnt_s),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    // Source rows of this line and the next one; the line after V_LAST is line 0.
    always_comb begin
        if (v_cnt_s == V_LAST) begin
            v_next_s = '0;
        end else begin
            v_next_s = v_cnt_s + V_CNT_W'(1);
        end
`ifdef SCREEN_SCANNER_LINE_DOUBLE_EN
        row_s      = v_cnt_s[8:1];
        row_next_s = v_next_s[8:1];
`else
        row_s      = v_cnt_s[7:0];
        row_next_s = v_next_s[7:0];
`endif
        word_s      = h_cnt_s[8:4];
        active_s    = (h_cnt_s < H_END) && (v_cnt_s < V_END);
        last_word_s = (word_s == 5'd31);
    end

    // Fetch one word ahead inside a line; word 0 of the next line is requested at the
    // first blanking clock. Data lands two clocks after the address changes.
    always_comb begin
        addr_d  = addr_q;
        issue_d = 1'b0;
        if (active_s && (h_cnt_s[3:0] == 4'd0) && !last_word_s) begin
            addr_d  = row_col_to_addr(row_s, word_s + 5'd1);
            issue_d = 1'b1;
        end else if ((h_cnt_s == H_END) && (v_next_s < V_END)) begin
            addr_d  = row_col_to_addr(row_next_s, 5'd0);
            issue_d = 1'b1;
        end else begin
            addr_d  = addr_q;
            issue_d = 1'b0;
        end
        capture_d = issue_q;
        if (capture_q) begin
            pf_d = scr_data;
        end else begin
            pf_d = pf_q;
        end
        // Reload after pixel 15 of each word, and just before pixel 0 of every line.
        if ((h_cnt_s == H_LAST) || (active_s && (h_cnt_s[3:0] == 4'd15) && !last_word_s)) begin
            sr_d = pf_q;
        end else begin
            sr_d = {1'b0, sr_q[15:1]};
        end
        if (active_s) begin
            pixel_d = sr_q[0];
        end else begin
            pixel_d = 1'b0;
        end
    end

    // Address, prefetch, shift and pixel registers; reset drops any fetch in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            issue_q   <= 1'b0;
            capture_q <= 1'b0;
            pf_q      <= '0;
            sr_q      <= '0;
            pixel_q   <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            issue_q   <= issue_d;
            capture_q <= capture_d;
            pf_q      <= pf_d;
            sr_q      <= sr_d;
            pixel_q   <= pixel_d;
        end
    end

    assign scr_address = addr_q;
    assign pixel       = pixel_q;

endmodule

// File: tb/tb_screen_scanner.sv
// Bench for screen_scanner: cycle scoreboard against a raster model plus a pixel vector table.
module tb_screen_scanner;
    localparam int H_FP = 2, H_SYNC = 2, H_BP = 2, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int H_TOTAL = 512 + H_FP + H_SYNC + H_BP;
`ifdef SCREEN_SCANNER_LINE_DOUBLE_EN
    localparam int V_ACT = 512;
    localparam bit LD = 1'b1;
`else
    localparam int V_ACT = 256;
    localparam bit LD = 1'b0;
`endif
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOTAL * V_TOTAL;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] scr_address, scr_data;
    logic pixel, de, hsync, vsync, frame_start;
    logic [15:0] mem [0:8191];

    typedef struct { int h; int v; logic de; logic hs; logic vs; logic fs; logic px; } exp_t;
    typedef struct { int phase; int slot; int px; logic exp; } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    logic cap [0:1][0:5][0:511];

    int checks = 0, errors = 0;
    int hm, vm, cyc, frame_m, phase, last_h, last_v;
    bit run_en = 1'b0;
    int fs_seen, fs_c1, fs_c2;
    int line_bad, bad_h;
    logic [4:0] bad_got, bad_want;
    int hs_low = 0, vs_low = 0, de_cnt = 0;
    int max_addr = 0, addr_short = 0, addr_fast = 0, held = 100;
    logic [15:0] prev_addr = 16'h0;

    screen_scanner #(
        .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .scr_address(scr_address), .scr_data(scr_data),
        .pixel(pixel), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous-read Screen model.
    always @(posedge clk) scr_data <= mem[scr_address[12:0]];

    function automatic exp_t model(input int h, input int v);
        exp_t e;
        logic [15:0] w;
        int row;
        e.h  = h;
        e.v  = v;
        e.de = (h < 512) && (v < V_ACT);
        e.hs = !((h >= 512 + H_FP) && (h < 512 + H_FP + H_SYNC));
        e.vs = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC));
        e.fs = (h == 0) && (v == 0);
        row  = LD ? (v / 2) : v;
        if (e.de) begin
            w    = mem[32 * row + h / 16];
            e.px = w[h % 16];
        end else begin
            e.px = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int ph, input int slot, input int px, input logic ex);
        vec_t t;
        t.phase = ph; t.slot = slot; t.px = px; t.exp = ex;
        vecs.push_back(t);
    endtask

    task automatic start_run(input int ph);
        reset   = 1'b0;
        phase   = ph;
        hm      = 0;
        vm      = V_TOTAL - 1;
        cyc     = 0;
        frame_m = 0;
        fs_seen = 0;
        fs_c1   = -1;
        fs_c2   = -1;
        line_bad = 0;
        run_en  = 1'b1;
    endtask

    // One clock: push the model's expectation at the edge, compare the DUT 1 ns later.
    task automatic tick();
        exp_t e;
        logic [4:0] got, want;
        @(posedge clk);
        if (run_en) begin
            sb_q.push_back(model(hm, vm));
            if (hm == H_TOTAL - 1) begin
                hm = 0;
                vm = (vm == V_TOTAL - 1) ? 0 : vm + 1;
            end else begin
                hm++;
            end
        end
        #1;
        cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.h == 0 && e.v == 0) frame_m++;
            last_h = e.h;
            last_v = e.v;
            got  = {de, hsync, vsync, frame_start, pixel};
            want = {e.de, e.hs, e.vs, e.fs, e.px};
            if (got !== want) begin
                if (line_bad == 0) begin
                    bad_h = e.h; bad_got = got; bad_want = want;
                end
                line_bad++;
            end
            if (e.h == H_TOTAL - 1) begin
                checks++;
                if (line_bad != 0) begin
                    errors++;
                    $display("FAIL sb_line p%0d v=%0d: %0d bad cycles, first h=%0d got %b expected %b (de,hs,vs,fs,px)",
                             phase, e.v, line_bad, bad_h, bad_got, bad_want);
                end
                line_bad = 0;
            end
            if (frame_start === 1'b1) begin
                fs_seen++;
                if (fs_seen == 1) fs_c1 = cyc;
                else if (fs_seen == 2) fs_c2 = cyc;
            end
            if (frame_m == 1 && e.h < 512) begin
                if (e.v < 5) cap[phase][e.v][e.h] = pixel;
                if (e.v == V_ACT - 1) cap[phase][5][e.h] = pixel;
            end
            if (phase == 0 && frame_m == 1) begin
                if (hsync === 1'b0) hs_low++;
                if (vsync === 1'b0) vs_low++;
                if (de === 1'b1) de_cnt++;
                if (e.v == V_TOTAL - 1 && e.h == 511) check("addr_last_word", scr_address, 32'd8191);
                if (e.v == V_TOTAL - 1 && e.h == H_TOTAL - 1) check("pf_line0_addr", scr_address, 32'd0);
            end
            if (int'(scr_address) > max_addr) max_addr = int'(scr_address);
            if (scr_address !== prev_addr) begin
                if (held < 2) addr_short++;
                if (e.h >= 1 && e.h <= 511 && held < 16) addr_fast++;
                held = 1;
            end else begin
                held++;
            end
            prev_addr = scr_address;
        end
    endtask

    initial begin
        logic [15:0] lit_a, lit_b;
        int guard;
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        mem[1]    = 16'd42;
        mem[2]    = 16'd23;
        mem[32]   = 16'h0001;
        mem[8191] = 16'h8000;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 6; s++)
                for (int x = 0; x < 512; x++) cap[p][s][x] = 1'bx;

        lit_a = 16'd42;
        lit_b = 16'd23;
        for (int i = 0; i < 16; i++) begin
            add(0, 0, 16 + i, lit_a[i]);
            add(0, 0, 32 + i, lit_b[i]);
            add(1, 0, 16 + i, 1'b1);
        end
        add(0, 0, 15, 1'b0);
        add(0, 0, 48, 1'b0);
        add(0, 5, 511, 1'b1);
        add(0, 5, 510, 1'b0);
        add(0, 5, 0, 1'b0);
        add(0, 1, 0, LD ? 1'b0 : 1'b1);
        add(0, 2, 0, LD ? 1'b1 : 1'b0);
        add(0, 3, 0, LD ? 1'b1 : 1'b0);
        add(0, 4, 0, 1'b0);
        add(1, 0, 0, 1'b1);
        add(1, 0, 15, 1'b0);
        add(1, 0, 32, 1'b0);

        #2 reset = 1'b1;
        #1 check("rst_init", {11'd0, scr_address, pixel, de, frame_start, hsync, vsync}, 32'h0000_0003);
        repeat (3) tick();

        // Phase 0: startup, one complete frame, then into frame 2.
        start_run(0);
        guard = 0;
        while (fs_seen < 2 && guard < FRAME + 2 * H_TOTAL) begin
            tick();
            guard++;
        end
        check("fs_first_cycle", fs_c1, H_TOTAL + 1);
        check("fs_period", fs_c2 - fs_c1, FRAME);
        check("hsync_low_clocks", hs_low, H_SYNC * V_TOTAL);
        check("vsync_low_clocks", vs_low, V_SYNC * H_TOTAL);
        check("de_high_clocks", de_cnt, 512 * V_ACT);

        guard = 0;
        while (!(frame_m == 2 && last_v == 100 && last_h == 250) && guard < 110 * H_TOTAL) begin
            tick();
            guard++;
        end
        check("reached_line100", {last_v[15:0], last_h[15:0]}, {16'd100, 16'd250});
        check("de_before_reset", de, 1'b1);

        // Mid-line reset: outputs must drop without waiting for a clock edge.
        reset = 1'b1;
        #1 check("rst_mid", {11'd0, scr_address, pixel, de, frame_start, hsync, vsync}, 32'h0000_0003);
        run_en = 1'b0;
        sb_q.delete();
        repeat (3) tick();
        check("rst_hold", {11'd0, scr_address, pixel, de, frame_start, hsync, vsync}, 32'h0000_0003);
        check("max_addr", max_addr, 8191);
        check("addr_hold_short", addr_short, 0);
        check("addr_fast_active", addr_fast, 0);

        // Phase 1: new Screen contents, restart from reset.
        mem[0] = 16'h0001;
        mem[1] = 16'hFFFF;
        mem[2] = 16'h0000;
        start_run(1);
        repeat (3 * H_TOTAL + 1) tick();
        check("fs_after_reset", fs_c1, H_TOTAL + 1);

        foreach (vecs[i]) begin
            checks++;
            if (cap[vecs[i].phase][vecs[i].slot][vecs[i].px] !== vecs[i].exp) begin
                errors++;
                $display("FAIL pix p%0d slot%0d x%0d: got %b expected %b", vecs[i].phase, vecs[i].slot,
                         vecs[i].px, cap[vecs[i].phase][vecs[i].slot][vecs[i].px], vecs[i].exp);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
